// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for the shared tristate data bus, with a one-cycle turnaround between owners.
// Optional grant timeout is compiled in when SHARED_BUS_ARB_TIMEOUT_EN is defined.
module shared_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           bus_en,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       preempt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
        $error("shared_bus_arbiter: N_REQ and MAX_HOLD must both be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last;

    logic                   found;
    logic [IDX_W-1:0]       winner;
    logic [N_REQ-1:0]       win_oh;
    int unsigned            idx;

    // Rotating priority search: walk from last+1 downward in priority so the nearest set bit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            idx = (32'(last) + i) % N_REQ;
            if (req[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
        win_oh = N_REQ'(1) << winner;
    end

`ifdef SHARED_BUS_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0]      hold_cnt;
    logic                   preempt_q;

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            bus_en    <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            last      <= IDX_W'(N_REQ - 1);
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
            preempt_q <= 1'b0;
`endif
            case (state)
                IDLE, TURN: begin
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= win_oh;
                        bus_en <= win_oh;
                        owner  <= winner;
                        last   <= winner;
                        busy   <= 1'b1;
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                GRANT: begin
                    // Any exit from GRANT drops every enable for one turnaround cycle.
                    if (!req[owner]) begin
                        state  <= TURN;
                        gnt    <= '0;
                        bus_en <= '0;
                        owner  <= '0;
                        busy   <= 1'b0;
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        state     <= TURN;
                        gnt       <= '0;
                        bus_en    <= '0;
                        owner     <= '0;
                        busy      <= 1'b0;
                        preempt_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end

                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    bus_en <= '0;
                    owner  <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Scoreboard bench for shared_bus_arbiter: a cycle model queues expected outputs per driven request vector.
module tb_shared_bus_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MAX_HOLD = 8;
`ifdef SHARED_BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] bus_en;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    shared_bus_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .bus_en (bus_en),
        .owner  (owner),
        .busy   (busy),
        .preempt(preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       preempt;
    } exp_t;

    typedef enum int {M_IDLE, M_GRANT, M_TURN} mstate_t;

    exp_t    sb_q[$];
    int      checks;
    int      failures;
    mstate_t m_state;
    int      m_owner;
    int      m_last;
    int      m_hold;
    logic    m_pre;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_owner = 0;
        m_last  = 3;
        m_hold  = 0;
        m_pre   = 1'b0;
        sb_q.delete();
    endtask

    // Reference behaviour for one rising edge with request vector r.
    task automatic model_step(input logic [3:0] r);
        int pick;
        pick  = -1;
        m_pre = 1'b0;
        if (m_state == M_GRANT) begin
            if (!r[m_owner]) begin
                m_state = M_TURN;
            end else if (TIMEOUT && m_hold == int'(MAX_HOLD) - 1) begin
                m_state = M_TURN;
                m_pre   = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
            end
            if (pick >= 0) begin
                m_state = M_GRANT;
                m_owner = pick;
                m_last  = pick;
                m_hold  = 0;
            end else begin
                m_state = M_IDLE;
            end
        end
    endtask

    task automatic cycle(input logic [3:0] r);
        exp_t e;
        req = r;
        model_step(r);
        e.gnt     = (m_state == M_GRANT) ? 4'(1 << m_owner) : 4'b0000;
        e.busy    = (m_state == M_GRANT);
        e.owner   = (m_state == M_GRANT) ? 2'(m_owner) : 2'd0;
        e.preempt = m_pre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("bus_en", 32'(bus_en), 32'(e.gnt));
            check("busy", 32'(busy), 32'(e.busy));
            check("owner", 32'(owner), 32'(e.owner));
            check("preempt", 32'(preempt), 32'(e.preempt));
            check("enable_onehot", 32'($countones(bus_en) <= 1), 32'd1);
        end
    endtask

    task automatic cycles(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) cycle(r);
    endtask

    initial begin
        logic [3:0] rv;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b1111;
        model_reset();

        // Reset holds everything quiet even with all requests up.
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        rst = 1'b0;

        cycle(4'b1111);
        check("first_gnt_idx0", 32'(gnt), 32'h1);
        cycles(4'b1110, 1);
        cycles(4'b0000, 3);

        // Single requester, held five cycles.
        cycles(4'b0100, 5);
        cycles(4'b0000, 3);

        // Owner 1 releases while 0 and 3 wait: index 3 is next in rotation.
        cycle(4'b0010);
        cycles(4'b1011, 3);
        cycle(4'b1001);
        check("rr_turn_gnt", 32'(gnt), 32'h0);
        cycle(4'b1001);
        check("rr_next_owner", 32'(gnt), 32'h8);
        cycles(4'b0000, 3);

        // Owner drops exactly where the timeout would fire.
        cycles(4'b0001, 8);
        cycle(4'b0000);
        check("drop_at_timeout_preempt", 32'(preempt), 32'd0);
        cycles(4'b0000, 2);

        // All requesters active, then one long-held request.
        cycles(4'b1111, 40);
        cycles(4'b0000, 2);
        cycles(4'b0010, 20);
        cycles(4'b0000, 2);

        // Sticky random request patterns.
        rv = 4'($urandom_range(0, 15));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
            cycle(rv);
        end

        // Async reset between edges while a grant is active.
        cycles(4'b0100, 4);
        check("pre_async_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_bus_en", 32'(bus_en), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(4'b0110);
        check("post_async_lowest", 32'(gnt), 32'h2);
        cycles(4'b0000, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
